sprite_fetch: RTL and testbench



---
 rtl/sprite_pkg.sv | 20 ++
 rtl/sprite_desc_table.sv | 79 +++++++
 rtl/sprite_fetch.sv | 186 ++++++++++++++++++
 tb/tb_sprite_fetch.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite address streamer: FSM encoding,
// default descriptor values and parameter defaults.
package sprite_pkg;

  localparam int unsigned NUM_OBJ_DEF = 64;
  localparam int unsigned ID_W_DEF    = 6;
  localparam int unsigned DIM_W_DEF   = 11;
  localparam int unsigned ADDR_W_DEF  = 19;

  localparam int unsigned DEF_H    = 1;
  localparam int unsigned DEF_W    = 1;
  localparam int unsigned DEF_BASE = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/sprite_desc_table.sv
// Writable sprite descriptor table {h, w, base} with a registered,
// read-before-write lookup port; out-of-range ids read as defaults.
module sprite_desc_table
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_OBJ = NUM_OBJ_DEF,
  parameter int unsigned ID_W    = ID_W_DEF,
  parameter int unsigned DIM_W   = DIM_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [DIM_W-1:0]  wr_h,
  input  logic [DIM_W-1:0]  wr_w,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic              rd_en,
  input  logic [ID_W-1:0]   rd_id,
  output logic [DIM_W-1:0]  rd_h,
  output logic [DIM_W-1:0]  rd_w,
  output logic [ADDR_W-1:0] rd_base
);

  logic [DIM_W-1:0]  h_mem    [NUM_OBJ];
  logic [DIM_W-1:0]  w_mem    [NUM_OBJ];
  logic [ADDR_W-1:0] base_mem [NUM_OBJ];

  logic [DIM_W-1:0]  rd_h_q, rd_h_d;
  logic [DIM_W-1:0]  rd_w_q, rd_w_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic              wr_hit;

  assign wr_hit  = we && (32'(wr_id) < NUM_OBJ);
  assign rd_h    = rd_h_q;
  assign rd_w    = rd_w_q;
  assign rd_base = rd_base_q;

  // Read samples the pre-write contents, so a same-cycle write is not seen.
  always_comb begin
    rd_h_d    = rd_h_q;
    rd_w_d    = rd_w_q;
    rd_base_d = rd_base_q;
    if (rd_en) begin
      if (32'(rd_id) < NUM_OBJ) begin
        rd_h_d    = h_mem[rd_id];
        rd_w_d    = w_mem[rd_id];
        rd_base_d = base_mem[rd_id];
      end else begin
        rd_h_d    = DIM_W'(DEF_H);
        rd_w_d    = DIM_W'(DEF_W);
        rd_base_d = ADDR_W'(DEF_BASE);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_OBJ; i++) begin
        h_mem[ID_W'(i)]    <= DIM_W'(DEF_H);
        w_mem[ID_W'(i)]    <= DIM_W'(DEF_W);
        base_mem[ID_W'(i)] <= ADDR_W'(DEF_BASE);
      end
      rd_h_q    <= DIM_W'(DEF_H);
      rd_w_q    <= DIM_W'(DEF_W);
      rd_base_q <= ADDR_W'(DEF_BASE);
    end else begin
      if (wr_hit) begin
        h_mem[wr_id]    <= wr_h;
        w_mem[wr_id]    <= wr_w;
        base_mem[wr_id] <= wr_base;
      end
      rd_h_q    <= rd_h_d;
      rd_w_q    <= rd_w_d;
      rd_base_q <= rd_base_d;
    end
  end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite ROM address streamer: looks up an object's descriptor and emits
// one ROM address per pixel, row by row, optionally mirrored horizontally.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_OBJ = NUM_OBJ_DEF,
  parameter int unsigned ID_W    = ID_W_DEF,
  parameter int unsigned DIM_W   = DIM_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic              req_flip,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [DIM_W-1:0]  pix_x,
  output logic [DIM_W-1:0]  pix_y,
  output logic              pix_last,
  output logic              done
);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              flip_q, flip_d;
  logic [DIM_W-1:0]  h_q, h_d;
  logic [DIM_W-1:0]  w_q, w_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              pix_valid_q, pix_valid_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [DIM_W-1:0]  pix_x_q, pix_x_d;
  logic [DIM_W-1:0]  pix_y_q, pix_y_d;
  logic              pix_last_q, pix_last_d;
  logic              done_q, done_d;

  logic              accept_c;
  logic              pix_hs_c;
  logic [DIM_W-1:0]  tbl_h, tbl_w;
  logic [ADDR_W-1:0] tbl_base;

  assign accept_c = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign pix_hs_c = pix_valid_q && pix_ready;

  sprite_desc_table #(
    .NUM_OBJ (NUM_OBJ),
    .ID_W    (ID_W),
    .DIM_W   (DIM_W),
    .ADDR_W  (ADDR_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we),
    .wr_id   (cfg_id),
    .wr_h    (cfg_h),
    .wr_w    (cfg_w),
    .wr_base (cfg_base),
    .rd_en   (accept_c),
    .rd_id   (req_id),
    .rd_h    (tbl_h),
    .rd_w    (tbl_w),
    .rd_base (tbl_base)
  );

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] rb,
                                                input logic [DIM_W-1:0]  w,
                                                input logic [DIM_W-1:0]  x,
                                                input logic              flip);
    logic [DIM_W-1:0] col;
    col = flip ? DIM_W'(w - x - DIM_W'(1)) : x;
    return rb + ADDR_W'(col);
  endfunction

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    flip_d      = flip_q;
    h_d         = h_q;
    w_d         = w_q;
    row_base_d  = row_base_q;
    pix_valid_d = pix_valid_q;
    pix_addr_d  = pix_addr_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_last_d  = pix_last_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          req_ready_d = 1'b0;
          flip_d      = req_flip;
          state_d     = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        h_d = tbl_h;
        w_d = tbl_w;
        if ((tbl_h == '0) || (tbl_w == '0)) begin
          done_d      = 1'b1;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          row_base_d  = tbl_base;
          pix_x_d     = '0;
          pix_y_d     = '0;
          pix_valid_d = 1'b1;
          pix_addr_d  = addr_of(tbl_base, tbl_w, '0, flip_q);
          pix_last_d  = (tbl_w == DIM_W'(1)) && (tbl_h == DIM_W'(1));
          state_d     = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pix_hs_c) begin
          if (pix_last_q) begin
            pix_valid_d = 1'b0;
            done_d      = 1'b1;
            req_ready_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            // Row advance accumulates the width instead of multiplying.
            if (pix_x_q == w_q - DIM_W'(1)) begin
              pix_x_d    = '0;
              pix_y_d    = pix_y_q + DIM_W'(1);
              row_base_d = row_base_q + ADDR_W'(w_q);
            end else begin
              pix_x_d = pix_x_q + DIM_W'(1);
            end
            pix_addr_d = addr_of(row_base_d, w_q, pix_x_d, flip_q);
            pix_last_d = (pix_x_d == w_q - DIM_W'(1)) && (pix_y_d == h_q - DIM_W'(1));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      flip_q      <= 1'b0;
      h_q         <= '0;
      w_q         <= '0;
      row_base_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_addr_q  <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      flip_q      <= flip_d;
      h_q         <= h_d;
      w_q         <= w_d;
      row_base_q  <= row_base_d;
      pix_valid_q <= pix_valid_d;
      pix_addr_q  <= pix_addr_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_last_q  <= pix_last_d;
      done_q      <= done_d;
    end
  end

  assign req_ready = req_ready_q;
  assign pix_valid = pix_valid_q;
  assign pix_addr  = pix_addr_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_last  = pix_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Scoreboard bench for sprite_fetch: a descriptor-table model predicts every
// pixel of each draw; a monitor pops and compares on each pixel handshake.
module tb_sprite_fetch;

  localparam int unsigned NUM_OBJ = 64;
  localparam int unsigned ID_W    = 6;
  localparam int unsigned DIM_W   = 11;
  localparam int unsigned ADDR_W  = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [ID_W-1:0]   cfg_id = '0;
  logic [DIM_W-1:0]  cfg_h = '0;
  logic [DIM_W-1:0]  cfg_w = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ID_W-1:0]   req_id = '0;
  logic              req_flip = 1'b0;
  logic              pix_valid;
  logic              pix_ready = 1'b1;
  logic [ADDR_W-1:0] pix_addr;
  logic [DIM_W-1:0]  pix_x, pix_y;
  logic              pix_last;
  logic              done;

  sprite_fetch #(
    .NUM_OBJ (NUM_OBJ),
    .ID_W    (ID_W),
    .DIM_W   (DIM_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_h     (cfg_h),
    .cfg_w     (cfg_w),
    .cfg_base  (cfg_base),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_flip  (req_flip),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_addr  (pix_addr),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_last  (pix_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int x;
    int y;
    int last;
  } pix_t;

  pix_t exp_q[$];
  int   exp_done = 0;
  int   checks = 0;
  int   errors = 0;
  int   m_h[NUM_OBJ];
  int   m_w[NUM_OBJ];
  int   m_base[NUM_OBJ];
  int   rdy_mode = 0;
  int   cur_hw = 0;

  bit                held = 1'b0;
  logic [ADDR_W-1:0] held_addr;
  logic [DIM_W-1:0]  held_x, held_y;
  logic              held_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NUM_OBJ); i++) begin
      m_h[i] = 1; m_w[i] = 1; m_base[i] = 0;
    end
  endtask

  // Pixel ready pattern: always, alternating, or random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ~pix_ready;
      default: pix_ready = 1'($urandom_range(1, 0));
    endcase
  end

  // Monitor: compares every handshaken pixel and every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && pix_valid) begin
        checks++;
        if (pix_addr != held_addr || pix_x != held_x || pix_y != held_y || pix_last != held_last) begin
          errors++;
          $display("FAIL hold_stable: got addr %0d x %0d y %0d last %0d, held addr %0d x %0d y %0d last %0d",
                   pix_addr, pix_x, pix_y, pix_last, held_addr, held_x, held_y, held_last);
        end
      end
      held = 1'b0;
      if (pix_valid && pix_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got addr %0d with no pixel expected", pix_addr);
        end else begin
          pix_t p;
          p = exp_q.pop_front();
          if (int'(pix_addr) != p.addr || int'(pix_x) != p.x || int'(pix_y) != p.y || int'(pix_last) != p.last) begin
            errors++;
            $display("FAIL pixel: got addr %0d x %0d y %0d last %0d, expected addr %0d x %0d y %0d last %0d",
                     pix_addr, pix_x, pix_y, pix_last, p.addr, p.x, p.y, p.last);
          end
        end
      end else if (pix_valid) begin
        held      = 1'b1;
        held_addr = pix_addr;
        held_x    = pix_x;
        held_y    = pix_y;
        held_last = pix_last;
      end
      if (done) begin
        checks++;
        if (exp_done == 0 || exp_q.size() != 0) begin
          errors++;
          $display("FAIL done_pulse: got done with %0d pixels pending, %0d done expected", exp_q.size(), exp_done);
        end else begin
          exp_done--;
        end
      end
    end
  end

  task automatic cfg_write(input int id, input int h, input int w, input int base);
    cfg_we = 1'b1; cfg_id = ID_W'(id); cfg_h = DIM_W'(h); cfg_w = DIM_W'(w); cfg_base = ADDR_W'(base);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_h[id] = h; m_w[id] = w; m_base[id] = base;
  endtask

  // Issues a request (optionally with a same-edge write to the same id);
  // returns in the LOOKUP cycle.
  task automatic issue_req(input int id, input int flip, input bit wr,
                           input int wh, input int ww, input int wb);
    int   n;
    pix_t p;
    n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", int'(req_ready), 1);
    req_valid = 1'b1; req_id = ID_W'(id); req_flip = flip[0];
    if (wr) begin
      cfg_we = 1'b1; cfg_id = ID_W'(id); cfg_h = DIM_W'(wh); cfg_w = DIM_W'(ww); cfg_base = ADDR_W'(wb);
    end
    for (int y = 0; y < m_h[id]; y++) begin
      for (int x = 0; x < m_w[id]; x++) begin
        p.addr = (m_base[id] + y * m_w[id] + ((flip != 0) ? (m_w[id] - 1 - x) : x)) & 32'h7FFFF;
        p.x    = x;
        p.y    = y;
        p.last = (x == m_w[id] - 1 && y == m_h[id] - 1) ? 1 : 0;
        exp_q.push_back(p);
      end
    end
    exp_done++;
    cur_hw = m_h[id] * m_w[id];
    @(posedge clk); #1;
    req_valid = 1'b0;
    cfg_we    = 1'b0;
    if (wr) begin
      m_h[id] = wh; m_w[id] = ww; m_base[id] = wb;
    end
    chk("lookup_req_ready", int'(req_ready), 0);
    chk("lookup_pix_valid", int'(pix_valid), 0);
  endtask

  task automatic wait_done(input bit timed, input bit chk_first);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 1'b0;
    while (!done && cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      if (!seen && pix_valid) begin
        seen = 1'b1;
        if (chk_first) chk("first_pix_latency", cnt, 1);
      end
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else if (timed) begin
      chk("done_latency", cnt, 1 + cur_hw);
    end
    if (cur_hw == 0) chk("zero_size_no_pixels", int'(seen), 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size() + exp_done, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int id, id2, h, w, b, fl;
    model_reset();
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_addr", int'(pix_addr), 0);
    chk("rst_pix_xy_last", int'(pix_x) + int'(pix_y) + int'(pix_last), 0);
    chk("rst_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_held_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req_ready", int'(req_ready), 1);

    // Basic stream, mirrored stream, stalled stream.
    cfg_write(0, 2, 3, 100);
    rdy_mode = 0;
    issue_req(0, 0, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);
    issue_req(0, 1, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);
    rdy_mode = 1;
    issue_req(0, 0, 1'b0, 0, 0, 0);
    wait_done(1'b0, 1'b1);
    rdy_mode = 0;

    // Zero-width descriptor.
    cfg_write(5, 2, 0, 300);
    issue_req(5, 0, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);

    // Default descriptor at the top id.
    issue_req(63, 1, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);

    // Writes to id0 while its stream is running leave the stream untouched.
    cfg_write(0, 3, 4, 500);
    rdy_mode = 1;
    issue_req(0, 0, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    cfg_write(0, 2, 2, 900);
    cfg_write(0, 1, 5, 1000);
    wait_done(1'b0, 1'b0);
    rdy_mode = 0;
    issue_req(0, 1, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);

    // Same-edge write and lookup: lookup sees the old descriptor.
    issue_req(0, 0, 1'b1, 1, 2, 77);
    wait_done(1'b1, 1'b1);
    issue_req(0, 0, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);

    // Wrap of the address modulo 2^19.
    cfg_write(9, 2, 3, 524286);
    issue_req(9, 1, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);

    // Reset at the third pixel of a 2x3 stream.
    cfg_write(0, 2, 3, 100);
    issue_req(0, 0, 1'b0, 0, 0, 0);
    begin
      int n;
      n = 0;
      while (exp_q.size() != 4 && n < 100) begin @(posedge clk); #1; n++; end
      chk("third_pixel_reached", exp_q.size(), 4);
    end
    chk("third_pixel_addr", int'(pix_addr), 102);
    rst = 1'b1;
    #1;
    chk("midrst_pix_valid", int'(pix_valid), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    chk("midrst_pix_addr", int'(pix_addr), 0);
    exp_q.delete();
    exp_done = 0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_release_req_ready", int'(req_ready), 1);
    issue_req(0, 0, 1'b0, 0, 0, 0);
    wait_done(1'b1, 1'b1);

    // Randomised traffic against the model.
    for (int it = 0; it < 30; it++) begin
      id = int'($urandom_range(63, 0));
      h  = int'($urandom_range(4, 0));
      w  = int'($urandom_range(5, 0));
      b  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(524287, 524270))
                                       : int'($urandom_range(524287, 0));
      if ($urandom_range(2, 0) != 0) cfg_write(id, h, w, b);
      id2 = ($urandom_range(1, 0) == 0) ? id : int'($urandom_range(63, 0));
      fl  = int'($urandom_range(1, 0));
      rdy_mode = int'($urandom_range(2, 0));
      if ($urandom_range(4, 0) == 0)
        issue_req(id2, fl, 1'b1, int'($urandom_range(3, 1)), int'($urandom_range(3, 0)),
                  int'($urandom_range(524287, 0)));
      else
        issue_req(id2, fl, 1'b0, 0, 0, 0);
      wait_done(rdy_mode == 0, 1'b1);
    end

    chk("final_drained", exp_q.size() + exp_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
